// File: rtl/demux1x8_reg.sv
// Registered 1-to-8 word distributor.
// One producer word is routed to a single channel chosen by in_sel, or to all
// eight channels when in_bcast is set. Each channel owns one output register
// and an EMPTY/FULL state bit, and drains independently through its own
// valid/ready handshake.
//
// Handshake rules, identical on the input side and on every output channel:
//   a transfer happens on a rising edge where valid and ready are both 1;
//   valid must not depend on ready; once valid is raised, the sender holds
//   valid and its payload stable until that transfer happens; ready may be
//   computed combinationally from the receiver's state.
module demux1x8_reg #(
    parameter int W  = 32,
    parameter int CW = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    input  logic [2:0]     in_sel,
    input  logic           in_bcast,
    output logic [7:0]     out_valid,
    input  logic [7:0]     out_ready,
    output logic [8*W-1:0] out_data,
    output logic           busy,
    output logic [CW-1:0]  xfer_cnt
);

    localparam int NCH = 8;

    // Per-channel state. out_valid is this state vector, so the channel FSMs
    // are directly observable on the port.
    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } ch_state_e;

    ch_state_e      state_q [NCH];
    ch_state_e      state_d [NCH];
    logic [W-1:0]   data_q  [NCH];
    logic [W-1:0]   data_d  [NCH];
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_d;

    logic [NCH-1:0] ch_free;
    logic [NCH-1:0] tgt_mask;
    logic [NCH-1:0] load;
    logic           sel_free;
    logic           all_free;
    logic           accept;

    // Input-side acceptance: a channel is free when empty or draining this
    // cycle, so a drain and a refill of the same channel can share an edge.
    // Broadcast needs every channel free so it never writes partially.
    always_comb begin
        ch_free  = '0;
        for (int k = 0; k < NCH; k++) begin
            ch_free[k] = (state_q[k] == CH_EMPTY) || out_ready[k];
        end
        sel_free = ch_free[in_sel];
        all_free = &ch_free;
        // Held off while reset is asserted so nothing is taken during reset.
        in_ready = rst_n & (in_bcast ? all_free : sel_free);
        accept   = in_valid & in_ready;
        tgt_mask = in_bcast ? {NCH{1'b1}} : (8'b0000_0001 << in_sel);
        load     = accept ? tgt_mask : '0;
    end

    // Channel next-state and data next-value; a load always wins over a drain.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            state_d[k] = state_q[k];
            data_d[k]  = data_q[k];
            case (state_q[k])
                CH_EMPTY: begin
                    if (load[k]) begin
                        state_d[k] = CH_FULL;
                        data_d[k]  = in_data;
                    end
                end
                CH_FULL: begin
                    if (load[k]) begin
                        state_d[k] = CH_FULL;
                        data_d[k]  = in_data;
                    end else if (out_ready[k]) begin
                        // Drained with no refill: data keeps its last value.
                        state_d[k] = CH_EMPTY;
                    end
                end
                default: begin
                    state_d[k] = CH_EMPTY;
                end
            endcase
        end
    end

    // Accepted-word counter: one per accept, broadcast included; wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // State, data and counter registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) begin
                state_q[k] <= CH_EMPTY;
                data_q[k]  <= '0;
            end
            cnt_q <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                state_q[k] <= state_d[k];
                data_q[k]  <= data_d[k];
            end
            cnt_q <= cnt_d;
        end
    end

    // Output packing: channel k occupies out_data[k*W +: W].
    always_comb begin
        out_valid = '0;
        out_data  = '0;
        for (int k = 0; k < NCH; k++) begin
            out_valid[k]         = (state_q[k] == CH_FULL);
            out_data[k*W +: W]   = data_q[k];
        end
        busy     = |out_valid;
        xfer_cnt = cnt_q;
    end

endmodule
